// File: rtl/fault_pkg.sv
// Shared types and fault-id helpers for the stuck-at fault campaign controller.
package fault_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRUN,
    ST_GWAIT,
    ST_SETUP,
    ST_RUN,
    ST_WAIT,
    ST_LOG,
    ST_FIN
  } state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

  // fault_id layout: bit 0 is the stuck value, the upper bits are the site index.
  function automatic logic [31:0] fid_pack(input logic [30:0] site, input logic stuck);
    return {site, stuck};
  endfunction

  function automatic logic [30:0] fid_site(input logic [31:0] id);
    return id[31:1];
  endfunction

  function automatic logic fid_stuck(input logic [31:0] id);
    return id[0];
  endfunction

endpackage

// File: rtl/fault_run_timer.sv
// Cycle counter measuring one DUT run; held at zero while clr is high.
module fault_run_timer
  import fault_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/fault_campaign_seq.sv
// Stuck-at fault campaign sequencer: golden run, then one faulted run per site/polarity.
module fault_campaign_seq
  import fault_pkg::*;
#(
  parameter int NUM_SITES = 64,
  parameter int RES_W     = 16,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int IDW       = $clog2(2 * NUM_SITES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             fault_en,
  output logic [IDW-1:0]   fault_id,
  output logic             dut_start,
  input  logic             dut_done,
  input  logic [RES_W-1:0] dut_result,
  output logic             det_valid,
  output logic [IDW-1:0]   det_id,
  output logic             det_hit,
  output logic             det_tmo,
  output logic [IDW:0]     hit_cnt,
  output logic             done,
  output logic             gold_err,
  output state_t           dbg_state
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(fid_pack(31'(NUM_SITES - 1), 1'b1));

  state_t           state;
  logic [RES_W-1:0] golden;
  logic             tmr_en;
  logic             tmr_exp;

  // Timer runs from the launch cycle onward, so expiry lands TIMEOUT cycles after dut_start.
  assign tmr_en    = (state == ST_GRUN) || (state == ST_GWAIT) ||
                     (state == ST_RUN)  || (state == ST_WAIT);
  assign dbg_state = state;

  fault_run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!tmr_en),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  // Outputs are registered alongside the state transition that implies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      fault_en  <= 1'b0;
      fault_id  <= '0;
      dut_start <= 1'b0;
      det_valid <= 1'b0;
      det_id    <= '0;
      det_hit   <= 1'b0;
      det_tmo   <= 1'b0;
      hit_cnt   <= '0;
      done      <= 1'b0;
      gold_err  <= 1'b0;
      golden    <= '0;
    end else begin
      dut_start <= 1'b0;
      det_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_GRUN;
            busy      <= 1'b1;
            dut_start <= 1'b1;
            hit_cnt   <= '0;
            gold_err  <= 1'b0;
            fault_id  <= '0;
          end
        end
        ST_GRUN: state <= ST_GWAIT;
        ST_GWAIT: begin
          if (dut_done) begin
            golden   <= dut_result;
            fault_en <= 1'b1;
            state    <= ST_SETUP;
          end else if (tmr_exp) begin
            gold_err <= 1'b1;
            done     <= 1'b1;
            state    <= ST_FIN;
          end
        end
        ST_SETUP: begin
          dut_start <= 1'b1;
          state     <= ST_RUN;
        end
        ST_RUN: state <= ST_WAIT;
        ST_WAIT: begin
          if (dut_done || tmr_exp) begin
            det_hit   <= dut_done ? (dut_result != golden) : 1'b1;
            det_tmo   <= !dut_done;
            det_id    <= fault_id;
            det_valid <= 1'b1;
            fault_en  <= 1'b0;
            state     <= ST_LOG;
          end
        end
        ST_LOG: begin
          hit_cnt <= hit_cnt + (IDW + 1)'(det_hit);
          if (fault_id == LAST_ID) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            fault_id <= fault_id + 1'b1;
            fault_en <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
